// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmit path.
package uart_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
    localparam int unsigned DATA_BITS            = 8;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_engine_if.sv
// Request/clear handshake and FIFO status between the UART control block and the TX engine.
interface uart_tx_engine_if;

    logic [uart_pkg::DATA_BITS-1:0] tx_data;
    logic                           tx_start;
    logic                           tx_start_clear;
    logic                           tx_busy;
    logic                           tx_empty;

    modport master (
        output tx_data,
        output tx_start,
        input  tx_start_clear,
        input  tx_busy,
        input  tx_empty
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output tx_start_clear,
        output tx_busy,
        output tx_empty
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
module uart_sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
        end
    end

    // Storage needs no reset; only entries behind the write pointer are ever read.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/uart_tx_engine.sv
// Buffered 8N1 UART transmitter. Define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_engine_if.slave    tx_bus,
    output logic               o_tx_active,
    output logic               o_tx_line
);

    localparam int unsigned FIFO_AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e              r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [2:0]             r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_tx_line;
    logic                   r_tx_active;
    logic                   r_tx_start_clear;
    logic                   r_tx_busy;
    logic                   r_tx_empty;
`ifdef UART_TX_PARITY_EN
    logic                   r_parity;
`endif

    logic                   w_push;
    logic                   w_pop;
    logic                   w_bit_last;
    logic                   w_frame_end;
    logic                   w_idle_nxt;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [DATA_BITS-1:0]   w_fifo_dout;
    logic [FIFO_AW:0]       w_fifo_count;
    logic [FIFO_AW:0]       w_count_nxt;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (tx_bus.tx_data),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // The clear pulse doubles as holdoff so a still-high request is not taken twice.
    assign w_push      = tx_bus.tx_start && !w_fifo_full && !r_tx_start_clear;
    assign w_bit_last  = (r_cnt == CNT_LAST);
    assign w_frame_end = (r_state == IDLE) || (r_state == STOP && w_bit_last);
    assign w_pop       = w_frame_end && !w_fifo_empty;
    assign w_idle_nxt  = w_frame_end && w_fifo_empty;
    assign w_count_nxt = w_fifo_count + {{FIFO_AW{1'b0}}, w_push}
                                      - {{FIFO_AW{1'b0}}, w_pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_start_clear <= 1'b0;
            r_tx_busy        <= 1'b0;
            r_tx_empty       <= 1'b1;
            r_tx_active      <= 1'b0;
        end else begin
            r_tx_start_clear <= w_push;
            r_tx_busy        <= (w_count_nxt == (FIFO_AW+1)'(FIFO_DEPTH));
            r_tx_empty       <= (w_count_nxt == '0) && w_idle_nxt;
            r_tx_active      <= !w_idle_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx_line <= IDLE_LVL;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx_line <= IDLE_LVL;
                    if (w_pop) begin
                        r_shift   <= w_fifo_dout;
`ifdef UART_TX_PARITY_EN
                        r_parity  <= ^w_fifo_dout;
`endif
                        r_cnt     <= '0;
                        r_state   <= START;
                        r_tx_line <= START_LVL;
                    end
                end
                START: begin
                    if (w_bit_last) begin
                        r_state   <= DATA;
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_tx_line <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_last) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            r_state   <= PARITY;
                            r_tx_line <= r_parity;
`else
                            r_state   <= STOP;
                            r_tx_line <= STOP_LVL;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                            r_tx_line <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_last) begin
                        r_state   <= STOP;
                        r_cnt     <= '0;
                        r_tx_line <= STOP_LVL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_last) begin
                        r_cnt <= '0;
                        // Chain straight into the next start bit when data is waiting.
                        if (w_pop) begin
                            r_shift   <= w_fifo_dout;
`ifdef UART_TX_PARITY_EN
                            r_parity  <= ^w_fifo_dout;
`endif
                            r_state   <= START;
                            r_tx_line <= START_LVL;
                        end else begin
                            r_state   <= IDLE;
                            r_tx_line <= IDLE_LVL;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_cnt     <= '0;
                    r_tx_line <= IDLE_LVL;
                end
            endcase
        end
    end

    assign tx_bus.tx_start_clear = r_tx_start_clear;
    assign tx_bus.tx_busy        = r_tx_busy;
    assign tx_bus.tx_empty       = r_tx_empty;
    assign o_tx_active           = r_tx_active;
    assign o_tx_line             = r_tx_line;

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Buffered UART transmitter.
- Accepts bytes from the UART register/control block through a level-request / clear-pulse handshake and stores them in a small FIFO.
- Serialises each byte as 8N1: start bit, 8 data bits LSB first, stop bit.
- Sits between the Wishbone-mapped UART control block and the chip TX pad. Drives the busy and empty indications that feed the Tx_full/Tx_empty status bits.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit; legal range 2 or more; 434 gives 115200 baud at 50 MHz.
- FIFO_DEPTH, 4, byte entries; must be a power of two, 2 or more.
- FIFO_AW, $clog2(FIFO_DEPTH), pointer width; derived, never overridden.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_tx_data  in  8  byte to send; sampled only in the accept cycle.
- i_tx_start  in  1  level request: i_tx_data is valid.
- o_tx_start_clear  out  1  one-cycle pulse: byte accepted into FIFO.
- o_tx_busy  out  1  FIFO full; the requester must not issue a new request.
- o_tx_empty  out  1  FIFO empty and serializer idle (line quiet).
- o_tx_active  out  1  a frame is currently on the line.
- o_tx_line  out  1  serial output; idle high.

Behaviour:
- Reset is asynchronous and active-low; one clock.
- Reset values:
  - o_tx_line=1, o_tx_start_clear=0, o_tx_busy=0, o_tx_empty=1, o_tx_active=0.
  - FIFO pointers and count=0; FSM=IDLE; baud counter=0.
  - All outputs are registered.
- Accept:
  - A byte is accepted in cycle N when i_tx_start=1, the registered FIFO count < FIFO_DEPTH, and holdoff=0.
  - i_tx_data is written to FIFO[wr_ptr]; o_tx_start_clear=1 in cycle N+1.
  - holdoff=1 during N+1, so the still-high request is ignored for one cycle.
  - A request while the FIFO is full is ignored: no write, no clear pulse. It stays pending until space frees.
- Simultaneous push and pop: both take effect and the count is unchanged. Full is evaluated on the registered count, so a push against a full FIFO is not accepted in the same cycle as a pop.
- Pointers wrap modulo FIFO_DEPTH; count is FIFO_AW+1 bits wide.
- o_tx_busy = (count == FIFO_DEPTH); o_tx_empty = (count == 0) && FSM == IDLE. Both are registered from next-state values.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if the FIFO is non-empty, pop into the 8-bit shift register and go to START. Line is high.
  - START: line=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: line=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit. After bit_idx=7, go to STOP.
  - STOP: line=1 for CLKS_PER_BIT cycles. In its last cycle, if the FIFO is non-empty, pop and go directly to START (zero idle gap); else go to IDLE.
- Baud counter: runs 0..CLKS_PER_BIT-1 and reloads 0 on every state change, so every bit is exactly CLKS_PER_BIT cycles.
- Latency from an empty, idle block:
  - Accept in cycle N, pop in N+1, o_tx_line low from N+2.
  - Frame length is 10*CLKS_PER_BIT cycles.
- o_tx_active=1 in START, DATA, STOP.
- Reset mid-frame: line returns high immediately (asynchronously); FIFO contents are discarded; no partial byte is resumed.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits, captured at pop) for CLKS_PER_BIT cycles.
  - Frame length is 11*CLKS_PER_BIT.
- Undefined: no PARITY state, no parity logic; 8N1 frames as above.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding: IDLE=0, START=1, DATA=2, STOP=3, PARITY=4, 3-bit.
  - Frame constants: DATA_BITS=8, START_LVL=0, STOP_LVL=1, IDLE_LVL=1.
  - Default CLKS_PER_BIT.
- One sub-module, uart_sync_fifo:
  - Parameterised by width 8 and depth.
  - Ports: push/din, pop/dout, full, empty, count.
  - Behaviour: registered read data valid in the pop cycle (first-word fall-through), write-before-read on the same address not required.
  - The engine keeps the handshake, holdoff, FSM and baud counter.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset held low mid-frame, released -> o_tx_line=1, o_tx_empty=1, o_tx_busy=0, no clear pulse; line stays high 50 cycles.
- Single byte 0xA5 requested from idle -> clear pulse at N+1; line low at N+2 for 4 cycles; bits 1,0,1,0,0,1,0,1 each 4 cycles; stop high 4; o_tx_empty=1 after 40 line cycles.
- Request held high for 5 bytes 0x01..0x05 while line busy:
  - One clear pulse per accepted byte, each separated by at least 1 cycle of holdoff.
  - o_tx_busy=1 when 4 are queued; the 5th is accepted only after the first pop.
  - All 5 frames are back-to-back with zero idle cycles between stop and next start.
- Request while o_tx_busy=1 with i_tx_start held 20 cycles -> no clear pulse and FIFO unchanged until the pop; accepted on the cycle after the pop registers.
- With UART_TX_PARITY_EN, send 0x07 -> parity bit 1 after data, frame 44 cycles; send 0x03 -> parity bit 0.
